// File: rtl/agu_pkg.sv
// Shared definitions for the AGU issue controller: memory op encodings,
// op-class helpers and the serialisation FSM state type.
package agu_pkg;

  localparam logic [3:0] LD_B   = 4'd0;
  localparam logic [3:0] LD_H   = 4'd1;
  localparam logic [3:0] LD_W   = 4'd2;
  localparam logic [3:0] LD_BU  = 4'd3;
  localparam logic [3:0] LD_HU  = 4'd4;
  localparam logic [3:0] ST_B   = 4'd5;
  localparam logic [3:0] ST_H   = 4'd6;
  localparam logic [3:0] ST_W   = 4'd7;
  localparam logic [3:0] LL     = 4'd8;
  localparam logic [3:0] SC     = 4'd9;
  localparam logic [3:0] PRELD  = 4'd10;
  localparam logic [3:0] CACOP  = 4'd11;
  localparam logic [3:0] INVTLB = 4'd12;
  localparam logic [3:0] DBAR   = 4'd13;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_CACOP  = 2'd1,
    WAIT_INVTLB = 2'd2,
    WAIT_BAR    = 2'd3
  } agu_state_t;

  // SC allocates a store-buffer entry just like a plain store.
  function automatic logic is_store(input logic [3:0] op);
    return (op == ST_B) || (op == ST_H) || (op == ST_W) || (op == SC);
  endfunction

  function automatic logic is_serial(input logic [3:0] op);
    return (op == CACOP) || (op == INVTLB) || (op == DBAR);
  endfunction

endpackage

// File: rtl/agu_issue_ctrl_sb_credit_cnt.sv
// Store-buffer credit counter: down on a granted store, up on an entry release,
// saturating at DEPTH. The empty flag is registered from the next count.
module sb_credit_cnt #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic empty
);

  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;

  assign full = (count == CW'(DEPTH));

  always_comb begin
    count_nxt = count;
    if (dec && !inc && (count != '0)) begin
      count_nxt = count - CW'(1);
    end else if (inc && !dec && !full) begin
      count_nxt = count + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= CW'(DEPTH);
      empty <= 1'b0;
    end else begin
      count <= count_nxt;
      empty <= (count_nxt == '0);
    end
  end

  // A release with every credit already home means the store buffer lost track.
  a_release_at_full: assert property (@(posedge clk) disable iff (!rst_n) !(inc && !dec && full));

endmodule

// File: rtl/agu_issue_ctrl.sv
// AGU issue controller: grants the selected memory op into a one-entry AGU stage,
// tracks store-buffer credits and serialises CACOP/INVTLB/DBAR.
module agu_issue_ctrl
  import agu_pkg::*;
#(
  parameter int SB_DEPTH = 8,
  parameter int ROB_ID_W = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                sel_vld,
  input  logic [3:0]          sel_op,
  input  logic [16:0]         sel_imm,
  input  logic                sel_dest_en,
  input  logic [6:0]          sel_dest,
  input  logic [6:0]          sel_source1,
  input  logic [6:0]          sel_source2,
  input  logic [ROB_ID_W-1:0] sel_ROB_ID,
  output logic                sel_grant,
  input  logic [ROB_ID_W-1:0] rob_head_ID,
  input  logic                sb_release,
  input  logic                serial_done,
  input  logic                lsu_stall,
  output logic                agu_vld,
  output logic [3:0]          agu_op,
  output logic [16:0]         agu_imm,
  output logic                agu_dest_en,
  output logic [6:0]          agu_dest,
  output logic [6:0]          agu_source1,
  output logic [6:0]          agu_source2,
  output logic [ROB_ID_W-1:0] agu_ROB_ID,
  output logic                CACOP_already,
  output logic                INVTLB_already,
  output logic                store_buffer_full,
  output logic                AGU_busy
);

  agu_state_t state;
  agu_state_t state_nxt;
  logic       credits_full;
  logic       class_ok;
  logic       grant_store;

  sb_credit_cnt #(.DEPTH(SB_DEPTH)) u_credit (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sb_release),
    .dec   (grant_store),
    .full  (credits_full),
    .empty (store_buffer_full)
  );

  assign AGU_busy = (agu_vld & lsu_stall) | (state != IDLE);

  // Serial ops need a quiet machine: oldest in ROB, store buffer drained, AGU empty.
  always_comb begin
    class_ok = 1'b1;
    if (is_store(sel_op)) begin
      class_ok = !store_buffer_full;
    end else if (is_serial(sel_op)) begin
      class_ok = (sel_ROB_ID == rob_head_ID) && credits_full && !agu_vld;
    end
  end

  assign sel_grant   = sel_vld & ~flush & ~AGU_busy & class_ok;
  assign grant_store = sel_grant & is_store(sel_op);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (sel_grant) begin
          if (sel_op == CACOP)       state_nxt = WAIT_CACOP;
          else if (sel_op == INVTLB) state_nxt = WAIT_INVTLB;
          else if (sel_op == DBAR)   state_nxt = WAIT_BAR;
        end
      end
      WAIT_CACOP, WAIT_INVTLB, WAIT_BAR: begin
        if (serial_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      CACOP_already  <= 1'b0;
      INVTLB_already <= 1'b0;
    end else begin
      state          <= state_nxt;
      CACOP_already  <= (state_nxt == WAIT_CACOP);
      INVTLB_already <= (state_nxt == WAIT_INVTLB);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      agu_vld     <= 1'b0;
      agu_op      <= '0;
      agu_imm     <= '0;
      agu_dest_en <= 1'b0;
      agu_dest    <= '0;
      agu_source1 <= '0;
      agu_source2 <= '0;
      agu_ROB_ID  <= '0;
    end else if (flush) begin
      agu_vld <= 1'b0;
    end else if (sel_grant) begin
      agu_vld     <= 1'b1;
      agu_op      <= sel_op;
      agu_imm     <= sel_imm;
      agu_dest_en <= sel_dest_en;
      agu_dest    <= sel_dest;
      agu_source1 <= sel_source1;
      agu_source2 <= sel_source2;
      agu_ROB_ID  <= sel_ROB_ID;
    end else if (!(agu_vld && lsu_stall)) begin
      agu_vld <= 1'b0;
    end
  end

endmodule
